dmem_arbiter: RTL
=================

# dmem_arbiter

Single-port data-memory arbiter sharing `dmem` between the processor's memory stage and a DMA/debug loader port. The CPU has default priority; a starvation counter promotes the DMA port after `MAX_WAIT` lost cycles, and the CPU is stalled for that cycle. The block sits in `top` between `processor` (memory-stage signals) and `dmem`. It adds a valid/ready handshake and registered read return for the DMA side.

## Interface
Parameters:
- `AW`, 6, memory address bits forwarded to `dmem`
- `MAX_WAIT`, 4, consecutive lost DMA cycles before forced DMA grant (legal range 1..15)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `i_CpuReq`  in  1  CPU memory-stage access request (load or store)
- `i_CpuWe`  in  1  CPU store
- `i_CpuAddr`  in  32  CPU byte address (`ALUResultM`)
- `i_CpuWData`  in  32  CPU store data (`WriteDataM`)
- `o_CpuRData`  out  32  load data, same cycle as grant
- `o_CpuStall`  out  1  CPU must hold its memory stage this cycle
- `i_DmaValid`  in  1  DMA request valid
- `i_DmaWe`  in  1  DMA write
- `i_DmaAddr`  in  32  DMA byte address
- `i_DmaWData`  in  32  DMA write data
- `o_DmaReady`  out  1  DMA request accepted this cycle
- `o_DmaRData`  out  32  registered DMA read data
- `o_DmaRValid`  out  1  `o_DmaRData` valid, one cycle pulse
- `o_MemWe`  out  1  to `dmem.we`
- `o_MemAddr`  out  AW  to `dmem.a` (selected address bits [AW-1:0], unchanged)
- `o_MemWData`  out  32  to `dmem.wd`
- `i_MemRData`  in  32  from `dmem.rd` (combinational read)

## Operation
- One memory access per cycle. The grant is combinational from the current state and requests, and steers `o_MemWe/Addr/WData`.
- State `ARB_CPU_PRIO`: grant CPU if `i_CpuReq`, else grant DMA if `i_DmaValid`.
- State `ARB_DMA_PRIO`: grant DMA if `i_DmaValid`, else grant CPU if `i_CpuReq`.
- `o_DmaReady` = DMA granted. `o_CpuStall` = `i_CpuReq` and CPU not granted.
- `o_CpuRData` = `i_MemRData` (valid only when CPU granted and not writing).
- Wait counter `wait_q` (4 bits) tracks starvation:
  - Increments when `i_DmaValid` and not `o_DmaReady`.
  - Clears on a DMA handshake.
  - Saturates at `MAX_WAIT`.
- Transitions:
  - CPU_PRIO→DMA_PRIO when the increment makes `wait_q == MAX_WAIT`.
  - DMA_PRIO→CPU_PRIO on a DMA handshake, or when `i_DmaValid` is low (this is a protocol violation, tolerated), with `wait_q` cleared.
- DMA handshake rule: once `i_DmaValid` rises, the DMA holds it and all DMA payload stable until `o_DmaReady`.
- CPU rule: while stalled, the CPU holds `i_CpuReq` and its payload.
- DMA read return: on a DMA read handshake, `o_DmaRData <= i_MemRData` and `o_DmaRValid <= 1` on the next cycle; otherwise `o_DmaRValid <= 0`.
- `o_DmaRData` holds its value between returns.

## Timing
- Reset values: state `ARB_CPU_PRIO`, `wait_q` 0, `o_DmaRValid` 0, `o_DmaRData` 0.
- During `rst`: `o_MemWe` forced 0, `o_DmaReady` 0, `o_CpuStall` 0. No write is committed in a reset cycle, even if requested.
- CPU latency: zero (same-cycle data). DMA read latency: 1 cycle after handshake. DMA write commits at the handshake edge.
- Worst-case DMA wait: `MAX_WAIT` cycles, then guaranteed grant. Worst-case CPU stall per DMA promotion: 1 cycle.
- Simultaneous requests with `wait_q < MAX_WAIT`: CPU wins.
- A reset asserted while DMA waits, or in DMA_PRIO, drops the pending promotion. The DMA keeps valid and restarts counting.
- Idle cycles (no requests): `o_MemWe` 0, `o_MemAddr` = CPU address, state and counter unchanged.

## Structure
- Package `dmem_arb_pkg`:
  - `typedef enum logic {ARB_CPU_PRIO, ARB_DMA_PRIO} arb_state_t`
  - `typedef enum logic {GNT_CPU, GNT_DMA} arb_gnt_t`
  - localparam `WAIT_W = 4`
- One natural sub-module, `arb_wait_counter` (saturating counter with inc/clr/`MAX_WAIT` compare, flag output).
- Remaining logic (FSM, mux, return register) is inline.

## Test plan
- Reset with `i_CpuReq=1`, `i_CpuWe=1` → `o_MemWe=0` throughout reset; after reset, `o_DmaRValid=0` and state is CPU_PRIO.
- DMA-only read at addr 0x08 with mem[0x08]=0xDEADBEEF → `o_DmaReady=1` the same cycle; next cycle `o_DmaRValid=1`, `o_DmaRData=0xDEADBEEF`.
- CPU and DMA both requesting continuously (`MAX_WAIT=4`) → CPU granted cycles 0–3 with stall 0. Cycle 4: DMA granted, `o_CpuStall=1`. Cycle 5: CPU granted again.
- CPU store 0x12345678 to 0x04 while DMA waits, then DMA read 0x04 → DMA returns 0x12345678.
- DMA drops valid while in DMA_PRIO → next cycle state is CPU_PRIO and `wait_q=0`; a CPU request in that cycle gets no stall.
- `rst` pulsed with `wait_q=3` and DMA valid held → after reset, DMA is forced-granted only after 4 further lost cycles.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Imported by dmem_arbiter and arb_wait_counter.
package dmem_arb_pkg;

    typedef enum logic {ARB_CPU_PRIO, ARB_DMA_PRIO} arb_state_t;
    typedef enum logic {GNT_CPU, GNT_DMA} arb_gnt_t;

    localparam int unsigned WAIT_W = 4;

    // Starvation limit as a counter-width value, clamped to the usable range 1..15.
    function automatic logic [WAIT_W-1:0] wait_limit(input int unsigned max_wait);
        logic [WAIT_W-1:0] lim;
        if (max_wait < 1) begin
            lim = WAIT_W'(1);
        end else if (max_wait > 15) begin
            lim = WAIT_W'(15);
        end else begin
            lim = WAIT_W'(max_wait);
        end
        return lim;
    endfunction

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating DMA starvation counter; o_hit flags the increment that reaches MAX_WAIT.
// Clear has priority over increment.
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam logic [WAIT_W-1:0] LIMIT = wait_limit(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;

    always_comb begin
        wait_d = wait_q;
        o_hit  = 1'b0;
        if (i_clr) begin
            wait_d = '0;
        end else if (i_inc && (wait_q != LIMIT)) begin
            wait_d = wait_q + 1'b1;
            o_hit  = (wait_d == LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU memory stage has default priority, the DMA/debug
// port is promoted after MAX_WAIT lost cycles and gets a registered read return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW       = 6,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_CpuReq,
    input  logic          i_CpuWe,
    input  logic [31:0]   i_CpuAddr,
    input  logic [31:0]   i_CpuWData,
    output logic [31:0]   o_CpuRData,
    output logic          o_CpuStall,
    input  logic          i_DmaValid,
    input  logic          i_DmaWe,
    input  logic [31:0]   i_DmaAddr,
    input  logic [31:0]   i_DmaWData,
    output logic          o_DmaReady,
    output logic [31:0]   o_DmaRData,
    output logic          o_DmaRValid,
    output logic          o_MemWe,
    output logic [AW-1:0] o_MemAddr,
    output logic [31:0]   o_MemWData,
    input  logic [31:0]   i_MemRData
);

    arb_state_t  state_q;
    arb_state_t  state_d;
    arb_gnt_t    gnt;
    logic        gnt_any;
    logic        cpu_gnt;
    logic        dma_gnt;
    logic        wait_inc;
    logic        wait_clr;
    logic        wait_hit;
    logic [31:0] dma_rdata_q;
    logic [31:0] dma_rdata_d;
    logic        dma_rvalid_q;
    logic        dma_rvalid_d;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{i_CpuAddr[31:AW], i_DmaAddr[31:AW]};

    always_comb begin
        gnt     = GNT_CPU;
        gnt_any = 1'b0;
        if (state_q == ARB_CPU_PRIO) begin
            if (i_CpuReq) begin
                gnt     = GNT_CPU;
                gnt_any = 1'b1;
            end else if (i_DmaValid) begin
                gnt     = GNT_DMA;
                gnt_any = 1'b1;
            end
        end else begin
            if (i_DmaValid) begin
                gnt     = GNT_DMA;
                gnt_any = 1'b1;
            end else if (i_CpuReq) begin
                gnt     = GNT_CPU;
                gnt_any = 1'b1;
            end
        end
    end

    // Reset masks every grant so no store can commit in a reset cycle.
    always_comb begin
        cpu_gnt    = !rst && gnt_any && (gnt == GNT_CPU);
        dma_gnt    = !rst && gnt_any && (gnt == GNT_DMA);
        o_DmaReady = dma_gnt;
        o_CpuStall = !rst && i_CpuReq && !cpu_gnt;
        o_CpuRData = i_MemRData;
        o_MemWe    = 1'b0;
        o_MemAddr  = i_CpuAddr[AW-1:0];
        o_MemWData = i_CpuWData;
        if (dma_gnt) begin
            o_MemWe    = i_DmaWe;
            o_MemAddr  = i_DmaAddr[AW-1:0];
            o_MemWData = i_DmaWData;
        end else if (cpu_gnt) begin
            o_MemWe    = i_CpuWe;
        end
    end

    assign wait_inc = i_DmaValid && !dma_gnt;
    assign wait_clr = dma_gnt || ((state_q == ARB_DMA_PRIO) && !i_DmaValid);

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .i_inc (wait_inc),
        .i_clr (wait_clr),
        .o_hit (wait_hit)
    );

    always_comb begin
        state_d      = state_q;
        dma_rvalid_d = dma_gnt && !i_DmaWe;
        dma_rdata_d  = dma_rvalid_d ? i_MemRData : dma_rdata_q;
        case (state_q)
            ARB_CPU_PRIO: if (wait_hit) state_d = ARB_DMA_PRIO;
            ARB_DMA_PRIO: if (dma_gnt || !i_DmaValid) state_d = ARB_CPU_PRIO;
            default:      state_d = ARB_CPU_PRIO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_CPU_PRIO;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign o_DmaRValid = dma_rvalid_q;
    assign o_DmaRData  = dma_rdata_q;

endmodule
